mem_io_responder: RTL and testbench

//  Byte-wide memory/IO responder: the far end of the memory controller's RAM bus (mem_addr/mem_rw/mem_dout->mem_din).

---
 rtl/mem_io_responder_if.sv | 23 ++
 rtl/mem_io_responder.sv | 146 ++++++++++++++
 tb/tb_mem_io_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
`default_nettype none
// ============================================================================
// mem_io_responder_if: controller-side byte RAM/IO bus. Revision 1.0
// ============================================================================
interface mem_io_responder_if;
  logic        rdy;
  logic [31:0] mem_addr;
  logic        mem_rw;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;

  modport master (
    output rdy, mem_addr, mem_rw, mem_wdata,
    input  mem_rdata, io_buffer_full
  );

  modport slave (
    input  rdy, mem_addr, mem_rw, mem_wdata,
    output mem_rdata, io_buffer_full
  );
endinterface
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// mem_io_responder: byte RAM plus memory-mapped TX FIFO, RX port, status, halt.
// Revision 1.0
// ============================================================================
module mem_io_responder #(
  parameter int RAM_AW      = 17,
  parameter int TXF_AW      = 3,
  parameter int FULL_MARGIN = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mem_io_responder_if.slave   bus,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  wire logic           tx_ready,
  input  wire logic [7:0]     rx_data,
  input  wire logic           rx_valid,
  output logic                rx_ready,
  output logic                tx_overflow,
  output logic                sim_halt
);

  localparam int                DEPTH    = 2 ** TXF_AW;
  localparam logic [TXF_AW:0]   DEPTH_C  = (TXF_AW + 1)'(DEPTH);
  localparam logic [TXF_AW:0]   MARGIN_C = (TXF_AW + 1)'(FULL_MARGIN);
  localparam logic [TXF_AW-1:0] PTR_ONE  = {{(TXF_AW - 1){1'b0}}, 1'b1};

  logic              is_io;
  logic [2:0]        reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              bus_en;
  logic              ram_we;
  logic              push_req;
  logic              halt_wr;
  logic              unused_addr;

  assign is_io       = (bus.mem_addr[17:16] == 2'b11);
  assign reg_sel     = bus.mem_addr[2:0];
  assign ram_idx     = bus.mem_addr[RAM_AW-1:0];
  assign bus_en      = bus.rdy & ~rst;
  assign ram_we      = bus_en & ~is_io & bus.mem_rw;
  assign push_req    = bus_en & is_io & bus.mem_rw & (reg_sel == 3'd0);
  assign halt_wr     = bus_en & is_io & bus.mem_rw & (reg_sel == 3'd4);
  assign rx_ready    = bus_en & is_io & ~bus.mem_rw & (reg_sel == 3'd0) & rx_valid;
  assign unused_addr = ^bus.mem_addr[31:18];

  // RAM kept free of reset so it maps onto block RAM; the read register is
  // muxed with a resettable IO read register to give mem_rdata.
  logic [7:0] ram_q [2**RAM_AW];
  logic [7:0] ram_rd_q;
  logic [7:0] io_rd_d;
  logic [7:0] io_rd_q;
  logic       sel_ram_q;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= bus.mem_wdata;
    end
    if (bus.rdy && !is_io && !bus.mem_rw) begin
      ram_rd_q <= ram_q[ram_idx];
    end
  end

  always_comb begin
    io_rd_d = 8'h00;
    if (is_io && !bus.mem_rw) begin
      if (reg_sel == 3'd0) begin
        io_rd_d = rx_valid ? rx_data : 8'h00;
      end else if (reg_sel == 3'd4) begin
        io_rd_d = {6'b0, rx_valid, ~tx_valid};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_ram_q <= 1'b0;
      io_rd_q   <= 8'h00;
    end else if (bus.rdy) begin
      sel_ram_q <= ~is_io & ~bus.mem_rw;
      io_rd_q   <= io_rd_d;
    end
  end

  assign bus.mem_rdata = sel_ram_q ? ram_rd_q : io_rd_q;

  // TX FIFO; popping is driven by the UART side and ignores rdy.
  logic [7:0]        fifo_q [DEPTH];
  logic [TXF_AW-1:0] rd_ptr_q;
  logic [TXF_AW-1:0] wr_ptr_q;
  logic [TXF_AW:0]   count_q;
  logic [TXF_AW:0]   count_d;
  logic              full_q;
  logic              overflow_q;
  logic              halt_q;
  logic              pop;
  logic              push;
  logic              fifo_full;

  assign tx_valid  = (count_q != '0);
  assign tx_data   = fifo_q[rd_ptr_q];
  assign pop       = tx_valid & tx_ready;
  assign fifo_full = (count_q == DEPTH_C);
  assign push      = push_req & (~fifo_full | pop);
  assign count_d   = count_q + (TXF_AW + 1)'(push) - (TXF_AW + 1)'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= bus.mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      // Margin leaves room for the store already in flight when this rises.
      full_q  <= ((DEPTH_C - count_d) <= MARGIN_C);
      if (push_req && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (halt_wr) begin
        halt_q <= 1'b1;
      end
    end
  end

  assign bus.io_buffer_full = full_q;
  assign tx_overflow        = overflow_q;
  assign sim_halt           = halt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// tb_mem_io_responder: directed and random stimulus against a queue model.
// Revision 1.0
// ============================================================================
module tb_mem_io_responder;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       tx_overflow;
  logic       sim_halt;

  mem_io_responder_if bus ();

  mem_io_responder dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_overflow (tx_overflow),
    .sim_halt    (sim_halt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] ram_m [int];
  logic [7:0] q_m [$];
  logic [7:0] exp_rdata = 8'h00;
  bit         rdata_known = 1'b0;
  bit         exp_full = 1'b0;
  bit         exp_ovf = 1'b0;
  bit         exp_halt = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d);
    bus.rdy       = r;
    bus.mem_addr  = a;
    bus.mem_rw    = w;
    bus.mem_wdata = d;
  endtask

  task automatic model_edge();
    bit io;
    int idx;
    int r;
    bit pop;
    bit push;
    io   = (bus.mem_addr[17:16] == 2'b11);
    idx  = int'(bus.mem_addr[16:0]);
    r    = int'(bus.mem_addr[2:0]);
    push = 1'b0;
    if (rst) begin
      q_m.delete();
      exp_rdata   = 8'h00;
      rdata_known = 1'b1;
      exp_full    = 1'b0;
      exp_ovf     = 1'b0;
      exp_halt    = 1'b0;
      return;
    end
    pop = (q_m.size() > 0) && tx_ready;
    if (bus.rdy) begin
      rdata_known = 1'b1;
      exp_rdata   = 8'h00;
      if (!io) begin
        if (bus.mem_rw) ram_m[idx] = bus.mem_wdata;
        else if (ram_m.exists(idx)) exp_rdata = ram_m[idx];
        else rdata_known = 1'b0;
      end else if (bus.mem_rw) begin
        if (r == 0) begin
          if (q_m.size() < 8 || pop) push = 1'b1;
          else exp_ovf = 1'b1;
        end else if (r == 4) begin
          exp_halt = 1'b1;
        end
      end else begin
        if (r == 0) exp_rdata = rx_valid ? rx_data : 8'h00;
        else if (r == 4) exp_rdata = {6'b0, rx_valid, q_m.size() == 0};
      end
    end
    if (pop) void'(q_m.pop_front());
    if (push) q_m.push_back(bus.mem_wdata);
    exp_full = (8 - q_m.size()) <= 2;
  endtask

  task automatic tick();
    bit exp_rx;
    #1;
    exp_rx = !rst && bus.rdy && (bus.mem_addr[17:16] == 2'b11) && !bus.mem_rw &&
             (bus.mem_addr[2:0] == 3'd0) && rx_valid;
    chk("rx_ready", rx_ready, exp_rx);
    model_edge();
    @(posedge clk);
    #1;
    if (rdata_known) chk("mem_rdata", bus.mem_rdata, exp_rdata);
    chk("io_buffer_full", bus.io_buffer_full, exp_full);
    chk("tx_valid", tx_valid, q_m.size() != 0);
    if (q_m.size() != 0) chk("tx_data", tx_data, q_m[0]);
    chk("tx_overflow", tx_overflow, exp_ovf);
    chk("sim_halt", sim_halt, exp_halt);
  endtask

  initial begin
    logic [7:0] t1 [4];
    logic [31:0] alist [8];
    t1    = '{8'h12, 8'h34, 8'h56, 8'h78};
    alist = '{32'h100, 32'h101, 32'h104, 32'h107, 32'h30000, 32'h30004, 32'h30001, 32'h30003};

    rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    set_bus(1'b1, 32'h0, 1'b0, 8'h00);
    tick(); tick();
    chk("reset_rdata", bus.mem_rdata, 8'h00);
    chk("reset_tx_valid", tx_valid, 1'b0);
    rst = 1'b0;

    // Test 1: back-to-back RAM writes then reads
    for (int i = 0; i < 4; i++) begin
      set_bus(1'b1, 32'h100 + i, 1'b1, t1[i]);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      set_bus(1'b1, 32'h100 + i, 1'b0, 8'h00);
      tick();
      chk("t1_read", bus.mem_rdata, t1[i]);
    end

    // Test 2: read-after-write, then rdy low freezes the bus side
    set_bus(1'b1, 32'h200, 1'b1, 8'hAA); tick();
    set_bus(1'b1, 32'h200, 1'b0, 8'h00); tick();
    chk("t2_raw", bus.mem_rdata, 8'hAA);
    for (int i = 0; i < 3; i++) begin
      set_bus(1'b0, 32'h200, 1'b1, 8'h55); tick();
      chk("t2_hold", bus.mem_rdata, 8'hAA);
    end
    set_bus(1'b1, 32'h200, 1'b0, 8'h00); tick();
    chk("t2_unchanged", bus.mem_rdata, 8'hAA);

    // Test 3: fill FIFO, margin flag, overflow
    for (int i = 1; i <= 9; i++) begin
      set_bus(1'b1, 32'h30000, 1'b1, 8'h41); tick();
      if (i == 5) chk("t3_full5", bus.io_buffer_full, 1'b0);
      if (i == 6) chk("t3_full6", bus.io_buffer_full, 1'b1);
      if (i == 8) chk("t3_ovf8", tx_overflow, 1'b0);
    end
    chk("t3_ovf9", tx_overflow, 1'b1);

    // Test 4: push+pop while full, then drain in order
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_bus(1'b1, 32'h30000, 1'b1, 8'h10 + 8'(i)); tick();
    end
    tx_ready = 1'b1;
    set_bus(1'b1, 32'h30000, 1'b1, 8'h99); tick();
    chk("t4_no_ovf", tx_overflow, 1'b0);
    set_bus(1'b1, 32'h100, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      chk("t4_order", tx_data, (i < 7) ? 8'h11 + 8'(i) : 8'h99);
      tick();
    end
    chk("t4_empty", tx_valid, 1'b0);

    // Test 5: RX port read
    rx_valid = 1'b1; rx_data = 8'h5A;
    set_bus(1'b1, 32'h30000, 1'b0, 8'h00);
    #1 chk("t5_rx_ready", rx_ready, 1'b1);
    tick();
    chk("t5_rdata", bus.mem_rdata, 8'h5A);
    rx_valid = 1'b0;
    tick();
    chk("t5_rdata_none", bus.mem_rdata, 8'h00);

    // Test 6: halt, then reset part-way through pushes
    tx_ready = 1'b0;
    set_bus(1'b1, 32'h30004, 1'b1, 8'h01); tick();
    chk("t6_halt", sim_halt, 1'b1);
    set_bus(1'b1, 32'h100, 1'b0, 8'h00); tick(); tick();
    chk("t6_halt_sticky", sim_halt, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_bus(1'b1, 32'h30000, 1'b1, 8'h60 + 8'(i)); tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    set_bus(1'b1, 32'h30000, 1'b1, 8'h63);
    chk("t6_tx_valid", tx_valid, 1'b0);
    chk("t6_halt_clr", sim_halt, 1'b0);
    chk("t6_full_clr", bus.io_buffer_full, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_bus(1'b1, 32'h100 + i, 1'b0, 8'h00); tick();
      chk("t6_ram_kept", bus.mem_rdata, t1[i]);
    end

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      tx_ready = $urandom_range(0, 2) == 0;
      rx_valid = $urandom_range(0, 1) == 1;
      rx_data  = 8'($urandom);
      set_bus($urandom_range(0, 4) != 0, alist[$urandom_range(0, 7)],
              $urandom_range(0, 1) == 1, 8'($urandom));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
